// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_pkg
//  Description : Shared constants for the multi-cycle MIPS sequencer:
//                opcodes, state encoding, ALUOp / ALUSrcB / PCSource codes
//                and small decode helpers.
//                Optional feature macro: MULTICYCLE_CTRL_JUMP_EN (J opcode).
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ORI    = 6'h0d;
  localparam logic [5:0] LUI    = 6'h0f;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2b;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] J      = 6'h02;

  // FSM states, 4-bit encoding; FETCH is zero so a forced-zero State reads as FETCH
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_R     = 4'd7,
    WB_I     = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10
`ifdef MULTICYCLE_CTRL_JUMP_EN
    ,
    JUMP     = 4'd11
`endif
  } state_t;

  // ALUOp codes
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;
  localparam logic [2:0] ALUOP_ADD   = 3'b100;
  localparam logic [2:0] ALUOP_OR    = 3'b101;
  localparam logic [2:0] ALUOP_LUI   = 3'b011;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;

  // ALUSrcB codes
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PCSource codes
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // State that follows DECODE for a given opcode; FETCH marks an unsupported opcode
  function automatic state_t decode_next(input logic [5:0] op);
    state_t s;
    s = FETCH;
    case (op)
      R_TYPE:             s = EXEC_R;
      ADDI, ORI, LUI:     s = EXEC_I;
      LW, SW:             s = MEM_ADDR;
      BEQ, BNE:           s = BRANCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
      J:                  s = JUMP;
`endif
      default:            s = FETCH;
    endcase
    return s;
  endfunction

  // ALU operation for the immediate-arithmetic group
  function automatic logic [2:0] itype_aluop(input logic [5:0] op);
    logic [2:0] a;
    a = ALUOP_ADD;
    if (op == ORI)      a = ALUOP_OR;
    else if (op == LUI) a = ALUOP_LUI;
    return a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_outdec.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_outdec
//  Description : Combinational output decoder: state + opcode -> raw control
//                strobes. Strobes that depend on MemReady/Zero are emitted as
//                separate enables and gated in the parent.
//                Optional feature macro: MULTICYCLE_CTRL_JUMP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_outdec
  import multicycle_control_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic [5:0] i_op,
  output logic       o_pcw_fetch,
  output logic       o_pcw_jump,
  output logic       o_br_eq,
  output logic       o_br_ne,
  output logic       o_irw_fetch,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_mem_to_reg,
  output logic       o_reg_dst,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_alu_op,
  output logic [1:0] o_pc_source,
  output logic       o_illegal
);

  // Per-state control decode; everything defaults to inactive
  always_comb begin
    o_pcw_fetch  = 1'b0;
    o_pcw_jump   = 1'b0;
    o_br_eq      = 1'b0;
    o_br_ne      = 1'b0;
    o_irw_fetch  = 1'b0;
    o_iord       = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_dst    = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = SRCB_B;
    o_alu_op     = 3'b000;
    o_pc_source  = PCSRC_ALU;
    o_illegal    = 1'b0;
    case (i_state)
      FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = SRCB_FOUR;
        o_alu_op    = ALUOP_ADD;
        o_pcw_fetch = 1'b1;
        o_irw_fetch = 1'b1;
      end
      DECODE: begin
        // Branch target precomputed into ALUOut
        o_alu_src_b = SRCB_IMM_SH;
        o_alu_op    = ALUOP_ADD;
        o_illegal   = (decode_next(i_op) == FETCH);
      end
      EXEC_R: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_B;
        o_alu_op    = ALUOP_RTYPE;
      end
      WB_R: begin
        o_reg_dst   = 1'b1;
        o_reg_write = 1'b1;
      end
      EXEC_I: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
        o_alu_op    = itype_aluop(i_op);
      end
      WB_I: begin
        o_reg_write = 1'b1;
        o_alu_op    = itype_aluop(i_op);
      end
      MEM_ADDR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
        o_alu_op    = ALUOP_ADD;
      end
      MEM_RD: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
      end
      WB_MEM: begin
        o_mem_to_reg = 1'b1;
        o_reg_write  = 1'b1;
      end
      MEM_WR: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
      end
      BRANCH: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_B;
        o_alu_op    = ALUOP_SUB;
        o_pc_source = PCSRC_ALUOUT;
        o_br_eq     = (i_op == BEQ);
        o_br_ne     = (i_op == BNE);
      end
`ifdef MULTICYCLE_CTRL_JUMP_EN
      JUMP: begin
        o_pc_source = PCSRC_JUMP;
        o_pcw_jump  = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multi-cycle MIPS sequencer. Holds the state register, the
//                latched opcode, next-state logic, MemReady/Zero gating of the
//                PC/IR strobes and forcing of all outputs during reset.
//                Optional feature macro: MULTICYCLE_CTRL_JUMP_EN (J support).
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op;
  logic [5:0] w_op;

  logic       w_pcw_fetch, w_pcw_jump, w_br_eq, w_br_ne, w_irw_fetch;
  logic       w_iord, w_mem_read, w_mem_write, w_mem_to_reg;
  logic       w_reg_dst, w_reg_write, w_alu_src_a, w_illegal;
  logic [1:0] w_alu_src_b, w_pc_source;
  logic [2:0] w_alu_op;
  logic       w_pcw;

  // OP is only trusted in DECODE; later states use the copy captured there
  assign w_op = (r_state == DECODE) ? OP : r_op;

  // State register and opcode latch, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FETCH;
      r_op    <= 6'h00;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) r_op <= OP;
    end
  end

  // Next-state logic; memory states wait for MemReady
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:    w_next = MemReady ? DECODE : FETCH;
      DECODE:   w_next = decode_next(OP);
      EXEC_R:   w_next = WB_R;
      WB_R:     w_next = FETCH;
      EXEC_I:   w_next = WB_I;
      WB_I:     w_next = FETCH;
      MEM_ADDR: w_next = (r_op == LW) ? MEM_RD : MEM_WR;
      MEM_RD:   w_next = MemReady ? WB_MEM : MEM_RD;
      WB_MEM:   w_next = FETCH;
      MEM_WR:   w_next = MemReady ? FETCH : MEM_WR;
      BRANCH:   w_next = FETCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
      JUMP:     w_next = FETCH;
`endif
      default:  w_next = FETCH;
    endcase
  end

  multicycle_control_outdec u_outdec (
    .i_state      (r_state),
    .i_op         (w_op),
    .o_pcw_fetch  (w_pcw_fetch),
    .o_pcw_jump   (w_pcw_jump),
    .o_br_eq      (w_br_eq),
    .o_br_ne      (w_br_ne),
    .o_irw_fetch  (w_irw_fetch),
    .o_iord       (w_iord),
    .o_mem_read   (w_mem_read),
    .o_mem_write  (w_mem_write),
    .o_mem_to_reg (w_mem_to_reg),
    .o_reg_dst    (w_reg_dst),
    .o_reg_write  (w_reg_write),
    .o_alu_src_a  (w_alu_src_a),
    .o_alu_src_b  (w_alu_src_b),
    .o_alu_op     (w_alu_op),
    .o_pc_source  (w_pc_source),
    .o_illegal    (w_illegal)
  );

  // Mealy PC write: fetch completes on MemReady, branch resolves on Zero
  assign w_pcw = (w_pcw_fetch & MemReady) | (w_br_eq & Zero) |
                 (w_br_ne & ~Zero) | w_pcw_jump;

  // Every output is held at zero while reset is low, cancelling in-flight writes
  assign PCWrite   = reset & w_pcw;
  assign IRWrite   = reset & w_irw_fetch & MemReady;
  assign IorD      = reset & w_iord;
  assign MemRead   = reset & w_mem_read;
  assign MemWrite  = reset & w_mem_write;
  assign MemtoReg  = reset & w_mem_to_reg;
  assign RegDst    = reset & w_reg_dst;
  assign RegWrite  = reset & w_reg_write;
  assign ALUSrcA   = reset & w_alu_src_a;
  assign ALUSrcB   = reset ? w_alu_src_b : 2'b00;
  assign ALUOp     = reset ? w_alu_op    : 3'b000;
  assign PCSource  = reset ? w_pc_source : 2'b00;
  assign IllegalOp = reset & w_illegal;
  assign State     = reset ? r_state     : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Directed self-checking bench for multicycle_control.
//                Honors MULTICYCLE_CTRL_JUMP_EN for the J-opcode case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, IorD, IRWrite, MemRead, MemWrite, MemtoReg;
  logic       RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] State;

  int n_vec = 0;
  int n_mis = 0;

  // State encodings
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2,
                         S_EXEC_I = 4'd3, S_MEM_ADDR = 4'd4, S_MEM_RD = 4'd5,
                         S_MEM_WR = 4'd6, S_WB_R = 4'd7, S_WB_I = 4'd8,
                         S_WB_MEM = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11;

  // Output vector order:
  // PCWrite,IorD,IRWrite,MemRead,MemWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,
  // ALUSrcB[1:0],ALUOp[2:0],PCSource[1:0],IllegalOp
  localparam logic [16:0] E_ZERO    = 17'b0;
  localparam logic [16:0] E_FETCH   = {9'b1_0_1_1_0_0_0_0_0, 2'b01, 3'b100, 2'b00, 1'b0};
  localparam logic [16:0] E_FETCH_W = {9'b0_0_0_1_0_0_0_0_0, 2'b01, 3'b100, 2'b00, 1'b0};
  localparam logic [16:0] E_DEC     = {9'b0_0_0_0_0_0_0_0_0, 2'b11, 3'b100, 2'b00, 1'b0};
  localparam logic [16:0] E_DEC_ILL = {9'b0_0_0_0_0_0_0_0_0, 2'b11, 3'b100, 2'b00, 1'b1};
  localparam logic [16:0] E_EXI_ADD = {9'b0_0_0_0_0_0_0_0_1, 2'b10, 3'b100, 2'b00, 1'b0};
  localparam logic [16:0] E_WBI_ADD = {9'b0_0_0_0_0_0_0_1_0, 2'b00, 3'b100, 2'b00, 1'b0};
  localparam logic [16:0] E_MADDR   = {9'b0_0_0_0_0_0_0_0_1, 2'b10, 3'b100, 2'b00, 1'b0};
  localparam logic [16:0] E_MRD     = {9'b0_1_0_1_0_0_0_0_0, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [16:0] E_WBM     = {9'b0_0_0_0_0_1_0_1_0, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [16:0] E_BR_T    = {9'b1_0_0_0_0_0_0_0_1, 2'b00, 3'b001, 2'b01, 1'b0};
  localparam logic [16:0] E_BR_NT   = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 3'b001, 2'b01, 1'b0};
  localparam logic [16:0] E_EXR     = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 3'b111, 2'b00, 1'b0};
  localparam logic [16:0] E_WBR     = {9'b0_0_0_0_0_0_1_1_0, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [16:0] E_MWR     = {9'b0_1_0_0_1_0_0_0_0, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [16:0] E_JMP     = {9'b1_0_0_0_0_0_0_0_0, 2'b00, 3'b000, 2'b10, 1'b0};

  logic [16:0] w_obs;
  assign w_obs = {PCWrite, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};

  multicycle_control dut (
    .clk       (clk),
    .reset     (reset),
    .OP        (OP),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .PCWrite   (PCWrite),
    .IorD      (IorD),
    .IRWrite   (IRWrite),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemtoReg  (MemtoReg),
    .RegDst    (RegDst),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .PCSource  (PCSource),
    .IllegalOp (IllegalOp),
    .State     (State)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, then check state and outputs
  task automatic step(input string tag, input logic rst_n, input logic [5:0] op,
                      input logic z, input logic mr,
                      input logic [3:0] exp_st, input logic [16:0] exp_vec);
    @(negedge clk);
    reset    = rst_n;
    OP       = op;
    Zero     = z;
    MemReady = mr;
    #1;
    check_val({tag, "/state"}, {28'd0, State}, {28'd0, exp_st});
    check_val({tag, "/ctl"},   {15'd0, w_obs}, {15'd0, exp_vec});
  endtask

  initial begin
    reset = 1'b0; OP = 6'h23; Zero = 1'b0; MemReady = 1'b1;

    // Reset held low: everything forced to zero
    step("rst0", 1'b0, 6'h23, 1'b0, 1'b1, 4'd0, E_ZERO);
    step("rst1", 1'b0, 6'h23, 1'b0, 1'b1, 4'd0, E_ZERO);
    step("rst2", 1'b0, 6'h23, 1'b0, 1'b1, 4'd0, E_ZERO);

    // ADDI; OP disturbed after DECODE must not matter
    step("addi_f",  1'b1, 6'h08, 1'b0, 1'b1, S_FETCH,  E_FETCH);
    step("addi_d",  1'b1, 6'h08, 1'b0, 1'b1, S_DECODE, E_DEC);
    step("addi_ex", 1'b1, 6'h3f, 1'b0, 1'b1, S_EXEC_I, E_EXI_ADD);
    step("addi_wb", 1'b1, 6'h0d, 1'b0, 1'b1, S_WB_I,   E_WBI_ADD);

    // LW with two wait cycles in MEM_RD
    step("lw_f",   1'b1, 6'h23, 1'b0, 1'b1, S_FETCH,    E_FETCH);
    step("lw_d",   1'b1, 6'h23, 1'b0, 1'b1, S_DECODE,   E_DEC);
    step("lw_a",   1'b1, 6'h2b, 1'b0, 1'b1, S_MEM_ADDR, E_MADDR);
    step("lw_r0",  1'b1, 6'h23, 1'b0, 1'b0, S_MEM_RD,   E_MRD);
    step("lw_r1",  1'b1, 6'h23, 1'b0, 1'b0, S_MEM_RD,   E_MRD);
    step("lw_r2",  1'b1, 6'h23, 1'b0, 1'b1, S_MEM_RD,   E_MRD);
    step("lw_wb",  1'b1, 6'h23, 1'b0, 1'b1, S_WB_MEM,   E_WBM);

    // BEQ taken, BNE not taken, both with Zero=1
    step("beq_f",  1'b1, 6'h04, 1'b1, 1'b1, S_FETCH,  E_FETCH);
    step("beq_d",  1'b1, 6'h04, 1'b1, 1'b1, S_DECODE, E_DEC);
    step("beq_b",  1'b1, 6'h04, 1'b1, 1'b1, S_BRANCH, E_BR_T);
    step("bne_f",  1'b1, 6'h05, 1'b1, 1'b1, S_FETCH,  E_FETCH);
    step("bne_d",  1'b1, 6'h05, 1'b1, 1'b1, S_DECODE, E_DEC);
    step("bne_b",  1'b1, 6'h05, 1'b1, 1'b1, S_BRANCH, E_BR_NT);

    // Illegal opcode: one-cycle pulse then back to FETCH
    step("ill_f",  1'b1, 6'h3f, 1'b0, 1'b1, S_FETCH,  E_FETCH);
    step("ill_d",  1'b1, 6'h3f, 1'b0, 1'b1, S_DECODE, E_DEC_ILL);
    step("j_f",    1'b1, 6'h02, 1'b0, 1'b1, S_FETCH,  E_FETCH);
`ifdef MULTICYCLE_CTRL_JUMP_EN
    step("j_d",    1'b1, 6'h02, 1'b0, 1'b1, S_DECODE, E_DEC);
    step("j_j",    1'b1, 6'h02, 1'b0, 1'b1, S_JUMP,   E_JMP);
`else
    step("j_d",    1'b1, 6'h02, 1'b0, 1'b1, S_DECODE, E_DEC_ILL);
`endif

    // R-type with one fetch wait cycle
    step("r_fw",   1'b1, 6'h00, 1'b0, 1'b0, S_FETCH,  E_FETCH_W);
    step("r_f",    1'b1, 6'h00, 1'b0, 1'b1, S_FETCH,  E_FETCH);
    step("r_d",    1'b1, 6'h00, 1'b0, 1'b1, S_DECODE, E_DEC);
    step("r_ex",   1'b1, 6'h00, 1'b0, 1'b1, S_EXEC_R, E_EXR);
    step("r_wb",   1'b1, 6'h00, 1'b0, 1'b1, S_WB_R,   E_WBR);

    // SW stalled in MEM_WR, then reset aborts it
    step("sw_f",   1'b1, 6'h2b, 1'b0, 1'b1, S_FETCH,    E_FETCH);
    step("sw_d",   1'b1, 6'h2b, 1'b0, 1'b1, S_DECODE,   E_DEC);
    step("sw_a",   1'b1, 6'h2b, 1'b0, 1'b1, S_MEM_ADDR, E_MADDR);
    step("sw_w0",  1'b1, 6'h2b, 1'b0, 1'b0, S_MEM_WR,   E_MWR);
    step("sw_rst", 1'b0, 6'h2b, 1'b0, 1'b0, 4'd0,       E_ZERO);
    step("sw_aft", 1'b1, 6'h2b, 1'b0, 1'b1, S_FETCH,    E_FETCH);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
